// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// It accepts one operation, registers the operands, captures the result and holds it until the consumer takes it.
module alu_arbiter #(
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_instr,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_instr,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic [31:0] alu_res,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_res,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   grant_id;
  logic   grant_sel;
  logic   accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Under contention, the requester that was not served last is granted.
  // Readies are gated by rst_n so that they drop as soon as reset asserts.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    grant_sel  = req0_valid && req1_valid ? ~last_grant : req1_valid;
    case (state)
      IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~grant_sel;
          req1_ready = grant_sel;
          state_next = EXEC;
        end
      end
      EXEC:    state_next = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_instr  <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      grant_id   <= 1'b0;
      last_grant <= ~FIRST_GRANT;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_res    <= '0;
    end else begin
      if (accept) begin
        alu_instr  <= grant_sel ? req1_instr : req0_instr;
        alu_op1    <= grant_sel ? req1_op1   : req0_op1;
        alu_op2    <= grant_sel ? req1_op2   : req0_op2;
        grant_id   <= grant_sel;
        last_grant <= grant_sel;
      end
      if (state == EXEC) begin
        rsp_res   <= alu_res;
        rsp_id    <= grant_id;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a small ALU model, a table of directed vectors, hand-written reset and backpressure sequences,
// and random traffic checked against a transaction-level round-robin model.
module tb_alu_arbiter;

  localparam logic [31:0] INSTR_ADD = 32'h0000_0033;
  localparam logic [31:0] INSTR_SUB = 32'h4000_0033;
  localparam logic [31:0] INSTR_XOR = 32'h0000_4033;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_instr, req0_op1, req0_op2;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_instr, req1_op1, req1_op2;
  logic [31:0] alu_instr, alu_op1, alu_op2, alu_res;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_res;
  logic        busy;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.FIRST_GRANT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_instr(req0_instr), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_instr(req1_instr), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .alu_instr(alu_instr), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res),
    .busy(busy)
  );

  // Shared ALU stand-in: decodes the R-type funct3/funct7 fields of the driven instruction.
  always_comb begin
    case (alu_instr[14:12])
      3'b000:  alu_res = alu_instr[30] ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
      3'b100:  alu_res = alu_op1 ^ alu_op2;
      3'b110:  alu_res = alu_op1 | alu_op2;
      3'b111:  alu_res = alu_op1 & alu_op2;
      default: alu_res = alu_op1 + alu_op2;
    endcase
  end

  typedef struct {
    bit          v0;
    bit          v1;
    logic [31:0] i0, a0, b0;
    logic [31:0] i1, a1, b1;
    bit          exp_id;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] refResult(input int kind, input logic [31:0] a, input logic [31:0] b);
    case (kind)
      0:       return a + b;
      1:       return a - b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [31:0] kindInstr(input int kind);
    case (kind)
      0:       return INSTR_ADD;
      1:       return INSTR_SUB;
      default: return INSTR_XOR;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic nextCycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset;
    @(negedge clk);
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    nextCycle();
    rst_n = 1'b1;
  endtask

  // One full transaction from a table record, with rsp_ready held high throughout.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    req0_valid = v.v0; req0_instr = v.i0; req0_op1 = v.a0; req0_op2 = v.b0;
    req1_valid = v.v1; req1_instr = v.i1; req1_op1 = v.a1; req1_op2 = v.b1;
    rsp_ready  = 1'b1;
    #1;
    checkOutput($sformatf("vec%0d req0_ready", idx), 32'(req0_ready), 32'(v.exp_id == 1'b0));
    checkOutput($sformatf("vec%0d req1_ready", idx), 32'(req1_ready), 32'(v.exp_id == 1'b1));
    nextCycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    checkOutput($sformatf("vec%0d exec rsp_valid", idx), 32'(rsp_valid), 32'd0);
    nextCycle();
    checkOutput($sformatf("vec%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
    checkOutput($sformatf("vec%0d rsp_id", idx), 32'(rsp_id), 32'(v.exp_id));
    checkOutput($sformatf("vec%0d rsp_res", idx), rsp_res, v.exp_res);
    nextCycle();
    checkOutput($sformatf("vec%0d done rsp_valid", idx), 32'(rsp_valid), 32'd0);
    checkOutput($sformatf("vec%0d done busy", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          v0, v1, g, any, model_last;
    int          k0, k1, dly;
    logic [31:0] a0, b0, a1, b1, exp_res;

    // Directed vectors; last-grant starts at 1 so requester 0 wins the first contention.
    vecs[0] = '{1, 1, INSTR_ADD, 32'h1, 32'h1, INSTR_SUB, 32'h10, 32'h1, 0, 32'h0000_0002};
    vecs[1] = '{1, 1, INSTR_ADD, 32'h1, 32'h1, INSTR_SUB, 32'h10, 32'h1, 1, 32'h0000_000F};
    vecs[2] = '{1, 1, INSTR_ADD, 32'h1, 32'h1, INSTR_SUB, 32'h10, 32'h1, 0, 32'h0000_0002};
    vecs[3] = '{1, 1, INSTR_ADD, 32'h1, 32'h1, INSTR_SUB, 32'h10, 32'h1, 1, 32'h0000_000F};
    vecs[4] = '{1, 0, INSTR_ADD, 32'h5, 32'h3, INSTR_SUB, 32'h9, 32'h9, 0, 32'h0000_0008};
    vecs[5] = '{1, 0, INSTR_ADD, 32'hFFFF_FFFF, 32'h1, INSTR_ADD, 32'h0, 32'h0, 0, 32'h0000_0000};
    vecs[6] = '{1, 1, INSTR_ADD, 32'h2, 32'h2, INSTR_SUB, 32'h10, 32'h1, 1, 32'h0000_000F};
    vecs[7] = '{0, 1, INSTR_ADD, 32'h3, 32'h3, INSTR_ADD, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000};
    vecs[8] = '{1, 1, INSTR_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, INSTR_ADD, 32'h1, 32'h1, 0, 32'hFF00_FF00};

    rst_n = 1'b0;
    req0_valid = 1'b1; req0_instr = INSTR_ADD; req0_op1 = 32'h5; req0_op2 = 32'h3;
    req1_valid = 1'b1; req1_instr = INSTR_SUB; req1_op1 = 32'h10; req1_op2 = 32'h1;
    rsp_ready  = 1'b0;
    #1;
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_res", rsp_res, 32'd0);
    checkOutput("reset alu_instr", alu_instr, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("reset req1_ready", 32'(req1_ready), 32'd0);
    nextCycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // Backpressure with a one-cycle req1 pulse that must never be served.
    @(negedge clk);
    req0_valid = 1'b1; req0_instr = INSTR_ADD; req0_op1 = 32'h7; req0_op2 = 32'h8;
    rsp_ready  = 1'b0;
    #1;
    checkOutput("bp req0_ready", 32'(req0_ready), 32'd1);
    nextCycle();
    req0_valid = 1'b0;
    #1;
    checkOutput("bp alu_op1", alu_op1, 32'h7);
    checkOutput("bp alu_op2", alu_op2, 32'h8);
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      req1_valid = (i == 1);
      req1_instr = INSTR_SUB; req1_op1 = 32'h40; req1_op2 = 32'h4;
      #1;
      checkOutput($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("bp%0d rsp_res", i), rsp_res, 32'h0000_000F);
      checkOutput($sformatf("bp%0d rsp_id", i), 32'(rsp_id), 32'd0);
      checkOutput($sformatf("bp%0d req0_ready", i), 32'(req0_ready), 32'd0);
      checkOutput($sformatf("bp%0d req1_ready", i), 32'(req1_ready), 32'd0);
      checkOutput($sformatf("bp%0d busy", i), 32'(busy), 32'd1);
      checkOutput($sformatf("bp%0d alu_op1", i), alu_op1, 32'h7);
      nextCycle();
    end
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    nextCycle();
    checkOutput("bp handshake rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp handshake busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput($sformatf("bp idle%0d busy", i), 32'(busy), 32'd0);
      checkOutput($sformatf("bp idle%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
    end

    // Reset asserted while holding a response.
    rsp_ready  = 1'b0;
    req1_valid = 1'b1; req1_instr = INSTR_SUB; req1_op1 = 32'h10; req1_op2 = 32'h1;
    #1;
    checkOutput("rr req1_ready", 32'(req1_ready), 32'd1);
    nextCycle();
    req1_valid = 1'b0;
    nextCycle();
    checkOutput("rr pre rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rr pre rsp_id", 32'(rsp_id), 32'd1);
    checkOutput("rr pre rsp_res", rsp_res, 32'h0000_000F);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    checkOutput("rr rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rr rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rr rsp_res", rsp_res, 32'd0);
    checkOutput("rr alu_instr", alu_instr, 32'd0);
    checkOutput("rr alu_op1", alu_op1, 32'd0);
    checkOutput("rr alu_op2", alu_op2, 32'd0);
    checkOutput("rr busy", 32'(busy), 32'd0);
    checkOutput("rr req0_ready", 32'(req0_ready), 32'd0);
    nextCycle();
    req0_valid = 1'b0;
    rsp_ready  = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("rr after%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
      nextCycle();
    end
    req0_valid = 1'b1; req0_instr = INSTR_ADD; req0_op1 = 32'h1; req0_op2 = 32'h1;
    req1_valid = 1'b1;
    #1;
    checkOutput("rr first contention req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("rr first contention req1_ready", 32'(req1_ready), 32'd0);
    nextCycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    nextCycle();
    checkOutput("rr new rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rr new rsp_res", rsp_res, 32'h0000_0002);
    nextCycle();

    // Reset asserted while the operation is executing; release and accept at once.
    req0_valid = 1'b1; req0_instr = INSTR_ADD; req0_op1 = 32'h11; req0_op2 = 32'h22;
    nextCycle();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("re busy", 32'(busy), 32'd0);
    nextCycle();
    rst_n = 1'b1;
    req1_valid = 1'b1; req1_instr = INSTR_XOR; req1_op1 = 32'hF0F0_F0F0; req1_op2 = 32'hFF00_FF00;
    #1;
    checkOutput("re first idle req1_ready", 32'(req1_ready), 32'd1);
    nextCycle();
    req1_valid = 1'b0;
    #1;
    checkOutput("re exec rsp_valid", 32'(rsp_valid), 32'd0);
    nextCycle();
    checkOutput("re rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("re rsp_id", 32'(rsp_id), 32'd1);
    checkOutput("re rsp_res", rsp_res, 32'h0FF0_0FF0);
    nextCycle();
    checkOutput("re done rsp_valid", 32'(rsp_valid), 32'd0);

    // Random traffic against a transaction-level round-robin model.
    doReset();
    model_last = 1'b1;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      k0 = $urandom_range(0, 2);
      k1 = $urandom_range(0, 2);
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      req0_valid = v0; req0_instr = kindInstr(k0); req0_op1 = a0; req0_op2 = b0;
      req1_valid = v1; req1_instr = kindInstr(k1); req1_op1 = a1; req1_op2 = b1;
      rsp_ready  = 1'b0;
      any = v0 | v1;
      g   = (v0 && v1) ? ~model_last : v1;
      #1;
      checkOutput($sformatf("rnd%0d req0_ready", it), 32'(req0_ready), 32'(any && !g));
      checkOutput($sformatf("rnd%0d req1_ready", it), 32'(req1_ready), 32'(any && g));
      if (!any) begin
        checkOutput($sformatf("rnd%0d idle busy", it), 32'(busy), 32'd0);
        continue;
      end
      model_last = g;
      exp_res = g ? refResult(k1, a1, b1) : refResult(k0, a0, b0);
      nextCycle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      nextCycle();
      checkOutput($sformatf("rnd%0d rsp_valid", it), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("rnd%0d rsp_id", it), 32'(rsp_id), 32'(g));
      checkOutput($sformatf("rnd%0d rsp_res", it), rsp_res, exp_res);
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) begin
        nextCycle();
        checkOutput($sformatf("rnd%0d hold%0d rsp_res", it, d), rsp_res, exp_res);
        checkOutput($sformatf("rnd%0d hold%0d rsp_valid", it, d), 32'(rsp_valid), 32'd1);
      end
      rsp_ready = 1'b1;
      nextCycle();
      checkOutput($sformatf("rnd%0d done rsp_valid", it), 32'(rsp_valid), 32'd0);
      rsp_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
